fetch_queue_unit: RTL

//  Parametrised instruction-fetch stage for the RISC-V datapath: owns the PC register, drives the

---
 rtl/fetch_queue_unit.sv | 90 +++++++++
 1 files changed

// File: rtl/fetch_queue_unit.sv
// Instruction-fetch stage: PC register, instruction-memory address and a DEPTH-entry
// {pc, instruction} FIFO with valid/ready output and a flushing redirect port.
module fetch_queue_unit #(
    parameter int               XLEN     = 32,
    parameter int               DEPTH    = 4,
    parameter logic [XLEN-1:0]  RESET_PC = '0
) (
    input  logic                         clk,
    input  logic                         reset,
    output logic [XLEN-1:0]              imem_addr,
    input  logic [XLEN-1:0]              imem_rdata,
    input  logic                         redirect_valid,
    input  logic [XLEN-1:0]              redirect_pc,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [XLEN-1:0]              out_pc,
    output logic [XLEN-1:0]              out_instr,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_count,
    output logic                         misalign_err
);

    localparam int              PW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int              CW         = $clog2(DEPTH + 1);
    localparam logic [CW-1:0]   FULL_COUNT = CW'(DEPTH);

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] pc_mem    [DEPTH];
    logic [XLEN-1:0] instr_mem [DEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [CW-1:0]   count;
    logic [XLEN-1:0] hold_pc;
    logic [XLEN-1:0] hold_instr;
    logic            pop;
    logic            push;

    assign imem_addr  = fetch_pc;
    assign fifo_count = count;
    assign out_valid  = (count != '0);
    assign pop        = out_valid && out_ready;
    assign push       = !redirect_valid && ((count != FULL_COUNT) || pop);

    // When empty, show the last value presented rather than stale storage (or 0 after reset).
    assign out_pc    = out_valid ? pc_mem[rd_ptr]    : hold_pc;
    assign out_instr = out_valid ? instr_mem[rd_ptr] : hold_instr;

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]    <= fetch_pc;
            instr_mem[wr_ptr] <= imem_rdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc     <= RESET_PC;
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            count        <= '0;
            hold_pc      <= '0;
            hold_instr   <= '0;
            misalign_err <= 1'b0;
        end else begin
            hold_pc      <= out_pc;
            hold_instr   <= out_instr;
            misalign_err <= 1'b0;
            if (redirect_valid) begin
                rd_ptr       <= '0;
                wr_ptr       <= '0;
                count        <= '0;
                fetch_pc     <= {redirect_pc[XLEN-1:2], 2'b00};
                misalign_err <= |redirect_pc[1:0];
            end else begin
                if (push) begin
                    wr_ptr   <= wr_ptr + PW'(1);
                    fetch_pc <= fetch_pc + XLEN'(4);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PW'(1);
                end
                case ({push, pop})
                    2'b10:   count <= count + CW'(1);
                    2'b01:   count <= count - CW'(1);
                    default: count <= count;
                endcase
            end
        end
    end

endmodule
